// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the
// sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BITPERCH = 4;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 10^n, used at elaboration time to find the largest representable value.
    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bcd_conv_seq.sv
// Sequential double-dabble converter: one input bit per cycle, valid/ready on both sides.
// Overflowing words render as all-0xF digits with ovf set.
module bcd_conv_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                         clk,
    input  logic                         RSTn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIN_W-1:0]             bin_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BITPERCH*DIGITS-1:0]   bcd_out,
    output logic                         ovf
);

    // Handshake rules: a word is taken on a rising edge where in_valid&in_ready;
    // a result is taken on a rising edge where out_valid&out_ready. in_ready
    // depends only on registered state, and results stay stable until taken.

    localparam int BCD_W = BITPERCH * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int TOT_W = BCD_W + BIN_W;
    localparam logic [63:0] MAX_DEC = 64'(pow10(DIGITS) - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   bin_r;
    logic [BCD_W-1:0]   bcd_r;
    logic               ovf_r;

    logic [BCD_W-1:0]   bcd_adj;
    logic [TOT_W-1:0]   shifted;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (bcd_r[g*BITPERCH +: BITPERCH]),
            .adjusted (bcd_adj[g*BITPERCH +: BITPERCH])
        );
    end

    // The bit leaving the top digit is dropped; ovf already flags that case.
    assign shifted  = {bcd_adj, bin_r} << 1;
    assign bcd_next = shifted[TOT_W-1:BIN_W];
    assign bin_next = shifted[BIN_W-1:0];

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            cnt       <= '0;
            bin_r     <= '0;
            bcd_r     <= '0;
            ovf_r     <= 1'b0;
            out_valid <= 1'b0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_r <= bin_in;
                        bcd_r <= '0;
                        cnt   <= CNT_W'(BIN_W);
                        ovf_r <= (64'(bin_in) > MAX_DEC);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_r <= bcd_next;
                    bin_r <= bin_next;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        bcd_out   <= ovf_r ? {DIGITS{DIGIT_BLANK}} : bcd_next;
                        ovf       <= ovf_r;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Self-checking bench for bcd_conv_seq: directed boundary cases plus a randomised
// sweep against an arithmetic decimal-digit reference model.
module tb_bcd_conv_seq;

    logic        clk;
    logic        RSTn;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  bin_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd_out;
    logic        ovf;

    int n_pass  = 0;
    int n_total = 0;

    logic [12:0] exp_q[$];

    bcd_conv_seq #(.BIN_W(10), .DIGITS(3)) dut (
        .clk       (clk),
        .RSTn      (RSTn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .ovf       (ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: {ovf, three decimal digits}, computed with plain arithmetic
    function automatic logic [12:0] ref_model(input int v);
        if (v > 999) return {1'b1, 12'hFFF};
        return {1'b0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // driver: one complete conversion; junk is driven on bin_in while busy
    task automatic do_conv(input logic [9:0] v, input int stall,
                           output logic [11:0] got, output logic got_ovf,
                           output int lat, output bit stable_ok, output bit drop_ok);
        int n;
        stable_ok = 1'b1;
        drop_ok   = 1'b0;
        got       = '0;
        got_ovf   = 1'b0;
        lat       = -1;
        @(negedge clk);
        in_valid = 1'b1;
        bin_in   = v;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        bin_in   = 10'($urandom_range(0, 1023));
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) return;
        got     = bcd_out;
        got_ovf = ovf;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!out_valid || bcd_out !== got || ovf !== got_ovf || in_ready)
                stable_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        drop_ok = !out_valid && in_ready;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        bin_in = '0;
        #1;
        n_total++;
        if ({in_ready, out_valid, bcd_out, ovf} !== {1'b1, 1'b0, 12'h000, 1'b0})
            $display("FAIL reset: got rdy=%b vld=%b bcd=%h ovf=%b, need 1 0 000 0",
                     in_ready, out_valid, bcd_out, ovf);
        else n_pass++;
        repeat (2) @(negedge clk);
        RSTn = 1'b1;
    endtask

    task automatic test_zero();
        logic [11:0] g; logic o; int lat; bit s, d;
        do_conv(10'd0, 0, g, o, lat, s, d);
        n_total++;
        if (lat !== 10) $display("FAIL zero_latency: got %0d need 10", lat);
        else n_pass++;
        n_total++;
        if ({o, g} !== 13'h0000) $display("FAIL zero_value: got ovf=%b bcd=%h need 0 000", o, g);
        else n_pass++;
        n_total++;
        if (!d) $display("FAIL zero_release: got drop_ok=%b need 1", d);
        else n_pass++;
    endtask

    task automatic test_boundary();
        int vals[4] = '{999, 1000, 1023, 9};
        logic [11:0] g; logic o; int lat; bit s, d; logic [12:0] e;
        foreach (vals[i]) begin
            e = ref_model(vals[i]);
            do_conv(10'(vals[i]), 1, g, o, lat, s, d);
            n_total++;
            if ({o, g} !== e)
                $display("FAIL boundary_%0d: got ovf=%b bcd=%h need ovf=%b bcd=%h",
                         vals[i], o, g, e[12], e[11:0]);
            else n_pass++;
            n_total++;
            if (lat !== 10) $display("FAIL boundary_latency_%0d: got %0d need 10", vals[i], lat);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [11:0] g; logic o; int lat; bit s, d;
        do_conv(10'd123, 5, g, o, lat, s, d);
        n_total++;
        if ({o, g} !== 13'h0123) $display("FAIL stall_value: got ovf=%b bcd=%h need 0 123", o, g);
        else n_pass++;
        n_total++;
        if (!s) $display("FAIL stall_stable: got stable=%b need 1", s);
        else n_pass++;
        n_total++;
        if (!d) $display("FAIL stall_drop: got drop_ok=%b need 1", d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [12:0] got_q[$];
        int t_q[$];
        int accepts = 0;
        logic [12:0] e;
        exp_q.push_back(ref_model(123));
        exp_q.push_back(ref_model(456));
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bin_in    = 10'd123;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (out_valid) begin
                got_q.push_back({ovf, bcd_out});
                t_q.push_back(cyc);
            end
            if (in_valid && in_ready) accepts++;
            @(negedge clk);
            if (accepts == 1) bin_in = 10'd456;
            else if (accepts >= 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        n_total++;
        if (got_q.size() !== 2) $display("FAIL b2b_count: got %0d results need 2", got_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (got_q.size() == 0) $display("FAIL b2b_value: got none need %h", e[11:0]);
            else if (got_q[0] !== e) begin
                $display("FAIL b2b_value: got %h need %h", got_q[0], e);
                void'(got_q.pop_front());
            end else begin
                void'(got_q.pop_front());
                n_pass++;
            end
        end
        n_total++;
        if (t_q.size() < 2) $display("FAIL b2b_spacing: got %0d results need 2", t_q.size());
        else if (t_q[1] - t_q[0] !== 12)
            $display("FAIL b2b_spacing: got %0d cycles need 12", t_q[1] - t_q[0]);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [11:0] g; logic o; int lat; bit s, d;
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        bin_in   = 10'd789;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        RSTn = 1'b0;
        #1;
        n_total++;
        if ({in_ready, out_valid, bcd_out, ovf} !== {1'b1, 1'b0, 12'h000, 1'b0})
            $display("FAIL async_reset: got rdy=%b vld=%b bcd=%h ovf=%b, need 1 0 000 0",
                     in_ready, out_valid, bcd_out, ovf);
        else n_pass++;
        @(negedge clk);
        RSTn = 1'b1;
        do_conv(10'd789, 0, g, o, lat, s, d);
        n_total++;
        if ({o, g} !== 13'h0789) $display("FAIL async_reconvert: got ovf=%b bcd=%h need 0 789", o, g);
        else n_pass++;
    endtask

    task automatic test_random_sweep();
        logic [11:0] g; logic o; int lat; bit s, d;
        logic [9:0] v;
        logic [12:0] e;
        for (int i = 0; i < 40; i++) begin
            v = 10'($urandom_range(0, 1023));
            exp_q.push_back(ref_model(int'(v)));
            do_conv(v, int'($urandom_range(0, 3)), g, o, lat, s, d);
            e = exp_q.pop_front();
            n_total++;
            if ({o, g} !== e || lat !== 10 || !s || !d)
                $display("FAIL random_%0d: got ovf=%b bcd=%h lat=%0d st=%b dr=%b need ovf=%b bcd=%h lat=10",
                         v, o, g, lat, s, d, e[12], e[11:0]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_boundary();
        test_stall();
        test_back_to_back();
        test_async_reset();
        test_random_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
